// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction memory loader
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_DONE     = 3'd3,
        ST_OVERFLOW = 3'd4
    } loader_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    function automatic int bytes_per_word(input int size, input int byte_w);
        return size / byte_w;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - packs input beats into words, flags the completed word
module byte_word_assembler
    import mips_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int BYTE_W     = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              i_clk_write,
    input  logic              i_rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [SIZE-1:0]   word,
    output logic              word_last,
    output logic              word_valid
);

    localparam int BPW   = bytes_per_word(SIZE, BYTE_W);
    localparam int CNT_W = $clog2(BPW + 1);

    logic [CNT_W-1:0] byte_cnt;
    logic [SIZE-1:0]  next_word;

    generate
        if (SIZE == BYTE_W) begin : g_single
            assign next_word = byte_in;
        end else if (BIG_ENDIAN) begin : g_big
            assign next_word = {word[SIZE-BYTE_W-1:0], byte_in};
        end else begin : g_little
            assign next_word = {byte_in, word[SIZE-1:BYTE_W]};
        end
    endgenerate

    assign word_last = accept && (byte_cnt == CNT_W'(BPW - 1));

    // word_valid is high in the cycle after the final beat, aligned with the loader's WRITE state
    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_last;
            if (accept) begin
                word     <= next_word;
                byte_cnt <= word_last ? '0 : byte_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot/debug byte-stream loader with instruction memory and read ports
module instr_mem_loader
    import mips_pkg::*;
#(
    parameter int              SIZE            = 32,
    parameter int              BYTE_W          = 8,
    parameter int              MAX_INSTRUCTION = 64,
    parameter int              ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
    parameter bit              BIG_ENDIAN      = 1'b1,
    parameter logic [SIZE-1:0] HALT_WORD       = SIZE'(HALT_WORD_DEFAULT)
) (
    input  logic                  i_clk_write,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [BYTE_W-1:0]     i_byte,
    output logic                  o_byte_ready,
    input  logic [ADDR_WIDTH-1:0] i_pc_addr,
    output logic [SIZE-1:0]       o_instruction,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic [SIZE-1:0]       o_dbg_data,
    output logic                  o_loading,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    generate
        if ((SIZE % BYTE_W) != 0) begin : g_bad_size
            $error("instr_mem_loader: SIZE must be a multiple of BYTE_W");
        end
    endgenerate

    loader_state_t         state, next_state;
    logic [SIZE-1:0]       mem [MAX_INSTRUCTION];
    logic [SIZE-1:0]       word;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  accept, word_last, word_valid, mem_we;
    logic                  halt_hit, at_last;
    logic                  pc_in_range, dbg_in_range;

    // i_start wins over a byte offered in the same cycle, even while already loading
    assign accept   = i_byte_valid && o_byte_ready && !i_start;
    assign halt_hit = (word == HALT_WORD);
    assign at_last  = (wr_ptr == ADDR_WIDTH'(MAX_INSTRUCTION - 1));

    byte_word_assembler #(
        .SIZE       (SIZE),
        .BYTE_W     (BYTE_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_assembler (
        .i_clk_write (i_clk_write),
        .i_rst       (i_rst),
        .clear       (i_start),
        .accept      (accept),
        .byte_in     (i_byte),
        .word        (word),
        .word_last   (word_last),
        .word_valid  (word_valid)
    );

    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (i_start) begin
            next_state = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:  if (word_last) next_state = ST_WRITE;
                ST_WRITE: begin
                    if (halt_hit)     next_state = ST_DONE;
                    else if (at_last) next_state = ST_OVERFLOW;
                    else              next_state = ST_LOAD;
                end
                default:  next_state = state;
            endcase
        end
    end

    always_comb begin
        o_byte_ready = (state == ST_LOAD);
        o_loading    = (state == ST_LOAD) || (state == ST_WRITE);
        o_done       = (state == ST_DONE);
        o_overflow   = (state == ST_OVERFLOW);
        mem_we       = (state == ST_WRITE) && word_valid && !i_start;
    end

    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            o_word_count <= '0;
        end else if (i_start) begin
            wr_ptr       <= '0;
            o_word_count <= '0;
        end else if (mem_we) begin
            o_word_count <= o_word_count + (ADDR_WIDTH+1)'(1);
            if (!halt_hit && !at_last) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk_write or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_INSTRUCTION; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[wr_ptr] <= word;
        end
    end

    // Range guard only matters when the depth leaves unused address codes
    generate
        if ((2 ** ADDR_WIDTH) > MAX_INSTRUCTION) begin : g_partial_depth
            assign pc_in_range  = ({1'b0, i_pc_addr}  < (ADDR_WIDTH+1)'(MAX_INSTRUCTION));
            assign dbg_in_range = ({1'b0, i_dbg_addr} < (ADDR_WIDTH+1)'(MAX_INSTRUCTION));
        end else begin : g_full_depth
            assign pc_in_range  = 1'b1;
            assign dbg_in_range = 1'b1;
        end
    endgenerate

    assign o_instruction = (pc_in_range && !o_loading) ? mem[i_pc_addr] : '0;
    assign o_dbg_data    = dbg_in_range ? mem[i_dbg_addr] : '0;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed bench for big-endian, little-endian and 4-deep loaders
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bvalid = 1'b0;
    logic [7:0] bdata = 8'h00;
    logic [5:0] pc_be = '0, dbg_be = '0, pc_le = '0, dbg_le = '0;
    logic [1:0] pc_sm = '0, dbg_sm = '0;

    logic        rdy_be, rdy_le, rdy_sm;
    logic [31:0] ins_be, ins_le, ins_sm, dd_be, dd_le, dd_sm;
    logic        ld_be, ld_le, ld_sm, dn_be, dn_le, dn_sm, ov_be, ov_le, ov_sm;
    logic [6:0]  wc_be, wc_le;
    logic [2:0]  wc_sm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.BIG_ENDIAN(1'b1)) dut_be (
        .i_clk_write(clk), .i_rst(rst), .i_start(start), .i_byte_valid(bvalid), .i_byte(bdata),
        .o_byte_ready(rdy_be), .i_pc_addr(pc_be), .o_instruction(ins_be), .i_dbg_addr(dbg_be),
        .o_dbg_data(dd_be), .o_loading(ld_be), .o_done(dn_be), .o_overflow(ov_be), .o_word_count(wc_be));

    instr_mem_loader #(.BIG_ENDIAN(1'b0)) dut_le (
        .i_clk_write(clk), .i_rst(rst), .i_start(start), .i_byte_valid(bvalid), .i_byte(bdata),
        .o_byte_ready(rdy_le), .i_pc_addr(pc_le), .o_instruction(ins_le), .i_dbg_addr(dbg_le),
        .o_dbg_data(dd_le), .o_loading(ld_le), .o_done(dn_le), .o_overflow(ov_le), .o_word_count(wc_le));

    instr_mem_loader #(.MAX_INSTRUCTION(4)) dut_sm (
        .i_clk_write(clk), .i_rst(rst), .i_start(start), .i_byte_valid(bvalid), .i_byte(bdata),
        .o_byte_ready(rdy_sm), .i_pc_addr(pc_sm), .o_instruction(ins_sm), .i_dbg_addr(dbg_sm),
        .o_dbg_data(dd_sm), .o_loading(ld_sm), .o_done(dn_sm), .o_overflow(ov_sm), .o_word_count(wc_sm));

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bdata  = b;
        bvalid = 1'b1;
        while (!rdy_be && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL send_byte_timeout: ready=%0b required=1", rdy_be);
        end
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy_be, ld_be, dn_be, ov_be, rdy_sm, ld_sm, dn_sm, ov_sm} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got=%b required=00000000",
                     {rdy_be, ld_be, dn_be, ov_be, rdy_sm, ld_sm, dn_sm, ov_sm});
        end
        checks++;
        if (wc_be !== 7'd0 || wc_sm !== 3'd0) begin
            failures++;
            $display("FAIL reset_word_count: be=%0d sm=%0d required=0", wc_be, wc_sm);
        end
        for (int a = 0; a < 64; a++) begin
            dbg_be = 6'(a);
            #1;
            checks++;
            if (dd_be !== 32'h0) begin
                failures++;
                $display("FAIL reset_mem[%0d]: got=%h required=00000000", a, dd_be);
            end
        end
        dbg_be = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_be !== 1'b0 || ld_be !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: ready=%0b loading=%0b required=0/0", rdy_be, ld_be);
        end
    endtask

    task automatic test_load_halt();
        logic [7:0] stream [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pulse_start();
        foreach (stream[i]) send_byte(stream[i]);
        @(negedge clk);
        dbg_be = 6'd0; dbg_le = 6'd0; dbg_sm = 2'd0; pc_be = 6'd0;
        #1;
        checks++;
        if (dd_be !== 32'h12345678) begin
            failures++; $display("FAIL be_word0: got=%h required=12345678", dd_be);
        end
        checks++;
        if (dd_le !== 32'h78563412) begin
            failures++; $display("FAIL le_word0: got=%h required=78563412", dd_le);
        end
        checks++;
        if (ins_be !== 32'h12345678) begin
            failures++; $display("FAIL fetch_after_done: got=%h required=12345678", ins_be);
        end
        dbg_be = 6'd1;
        #1;
        checks++;
        if (dd_be !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL be_word1_halt: got=%h required=ffffffff", dd_be);
        end
        checks++;
        if (dn_be !== 1'b1 || wc_be !== 7'd2 || ld_be !== 1'b0 || rdy_be !== 1'b0) begin
            failures++;
            $display("FAIL done_state: done=%0b count=%0d loading=%0b ready=%0b required=1/2/0/0",
                     dn_be, wc_be, ld_be, rdy_be);
        end
        checks++;
        if (dn_sm !== 1'b1 || ov_sm !== 1'b0 || wc_sm !== 3'd2) begin
            failures++;
            $display("FAIL sm_done: done=%0b ovf=%0b count=%0d required=1/0/2", dn_sm, ov_sm, wc_sm);
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_byte(8'h01);
        pc_be = 6'd0; dbg_be = 6'd0;
        #1;
        checks++;
        if (ld_be !== 1'b1 || ins_be !== 32'h0 || dd_be !== 32'h12345678) begin
            failures++;
            $display("FAIL fetch_masked: loading=%0b instr=%h dbg=%h required=1/00000000/12345678",
                     ld_be, ins_be, dd_be);
        end
        for (int i = 2; i <= 16; i++) send_byte(8'(i));
        @(negedge clk);
        checks++;
        if (ov_sm !== 1'b1 || dn_sm !== 1'b0 || wc_sm !== 3'd4 || rdy_sm !== 1'b0) begin
            failures++;
            $display("FAIL sm_overflow: ovf=%0b done=%0b count=%0d ready=%0b required=1/0/4/0",
                     ov_sm, dn_sm, wc_sm, rdy_sm);
        end
        bdata = 8'h55; bvalid = 1'b1;
        repeat (3) @(negedge clk);
        bvalid = 1'b0;
        checks++;
        if (rdy_sm !== 1'b0 || wc_sm !== 3'd4 || ov_sm !== 1'b1) begin
            failures++;
            $display("FAIL sm_extra_byte: ready=%0b count=%0d ovf=%0b required=0/4/1", rdy_sm, wc_sm, ov_sm);
        end
        dbg_sm = 2'd0;
        #1;
        checks++;
        if (dd_sm !== 32'h01020304) begin
            failures++; $display("FAIL sm_word0: got=%h required=01020304", dd_sm);
        end
        dbg_sm = 2'd3;
        #1;
        checks++;
        if (dd_sm !== 32'h0D0E0F10) begin
            failures++; $display("FAIL sm_word3: got=%h required=0d0e0f10", dd_sm);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        dbg_be = 6'd0; dbg_le = 6'd0;
        #1;
        checks++;
        if (dd_be !== 32'h11223344 || dd_le !== 32'h44332211) begin
            failures++;
            $display("FAIL restart_word0: be=%h le=%h required=11223344/44332211", dd_be, dd_le);
        end
        dbg_be = 6'd1; dbg_sm = 2'd1;
        #1;
        checks++;
        if (dd_be !== 32'h05060708 || dd_sm !== 32'h05060708) begin
            failures++;
            $display("FAIL restart_keeps_word1: be=%h sm=%h required=05060708", dd_be, dd_sm);
        end
        checks++;
        if (wc_be !== 7'd1 || dn_be !== 1'b0 || ov_sm !== 1'b0 || wc_sm !== 3'd1 || ld_be !== 1'b1) begin
            failures++;
            $display("FAIL restart_flags: count=%0d done=%0b sm_ovf=%0b sm_count=%0d loading=%0b required=1/0/0/1/1",
                     wc_be, dn_be, ov_sm, wc_sm, ld_be);
        end
    endtask

    task automatic test_reset_in_write();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++;
        if (ld_be !== 1'b1 || rdy_be !== 1'b0) begin
            failures++;
            $display("FAIL in_write_state: loading=%0b ready=%0b required=1/0", ld_be, rdy_be);
        end
        rst = 1'b1;
        dbg_be = 6'd0;
        #1;
        checks++;
        if (ld_be !== 1'b0 || wc_be !== 7'd0 || dd_be !== 32'h0 || ld_sm !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: loading=%0b count=%0d mem0=%h sm_loading=%0b required=0/0/00000000/0",
                     ld_be, wc_be, dd_be, ld_sm);
        end
        dbg_be = 6'd1;
        #1;
        checks++;
        if (dd_be !== 32'h0) begin
            failures++; $display("FAIL async_reset_mem1: got=%h required=00000000", dd_be);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dbg_be = 6'd2;
        #1;
        checks++;
        if (dd_be !== 32'h0 || rdy_be !== 1'b0 || ins_be !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_idle: mem2=%h ready=%0b instr=%h required=00000000/0/00000000",
                     dd_be, rdy_be, ins_be);
        end
    endtask

    initial begin
        test_reset();
        test_load_halt();
        test_overflow();
        test_restart();
        test_reset_in_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
